fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the instruction decoder.
- Holds the 6-bit program counter and fetches 32-bit words from the instruction memory using a req/ack handshake.
- Presents each fetched word to the decoder in an instruction register (IR).
- Samples the decoder's pc_inc/jmp/jmp_add/rst controls to compute the next PC.

Parameters:
- ADDR_W, 6, PC/imem address width (64-word program space)
- INST_W, 32, instruction width
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- imem_req  out  1  fetch request, high while in FETCH
- imem_addr  out  ADDR_W  fetch address (= pc), stable while imem_req high
- imem_ack  in  1  memory has imem_data valid this cycle
- imem_data  in  INST_W  fetched word
- inst  out  INST_W  IR contents, drives decoder inst input
- inst_valid  out  1  high for exactly one cycle per fetched instruction (EXEC)
- pc  out  ADDR_W  current program counter
- pc_inc  in  1  decoder: advance PC
- jmp  in  1  decoder: load jmp_add
- jmp_add  in  ADDR_W  decoder: jump target
- soft_rst  in  1  decoder rst output: force PC to 0
- inst_count  out  CNT_W  number of EXEC cycles since reset

Behaviour:
- Reset is synchronous and active-low on clk (rst_n sampled at rising edge). While rst_n=0 at an edge:
  - state<=IDLE, pc<=0, IR<=0 (opcode 00 = decoder default/NOP), inst_count<=0.
  - imem_req=0, inst_valid=0.
- FSM states are IDLE, FETCH and EXEC.
  - IDLE: imem_req=0. Next edge -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc. At an edge with imem_ack=1: IR<=imem_data, go to EXEC. Otherwise stay in FETCH, with req and addr held.
  - EXEC: inst_valid=1 and imem_req=0. The decoder outputs are combinational from IR and are sampled at the end of EXEC. Next-PC priority is:
    1. soft_rst=1 -> pc<=0
    2. else jmp=1 -> pc<=jmp_add
    3. else pc_inc=1 -> pc<=pc+1, modulo 2^ADDR_W (63 wraps to 0)
    4. else pc holds, so the same address is re-fetched (stall/halt loop).
  - EXEC also does inst_count<=inst_count+1 (wraps at 2^CNT_W) and then goes to FETCH.
- Latency and throughput:
  - ack in the first FETCH cycle gives 2 cycles per instruction.
  - Each ack wait cycle adds 1.
  - First request is issued 1 cycle after rst_n rises (IDLE).
- The handshake runs in the same cycle: ack is sampled on the edge where req=1. imem_ack while req=0 is ignored, and IR is unchanged.
- imem_addr and inst are registered and stable outside their update edges. inst holds its last value outside EXEC.
- Reset mid-fetch: the request is abandoned and req drops after that edge. Memory must tolerate a dropped req. Any late ack is ignored (state is IDLE).
- pc_inc and jmp are both high (not produced by the current decoder): jmp wins.
- pc and inst_count are only modified in EXEC or by reset.

Decomposition:
- Shared package: ADDR_W/INST_W constants, state enum (IDLE=2'd0, FETCH=2'd1, EXEC=2'd2), NOP opcode constant 8'h00, opcode constants (ALU 01-07, LOADI 10, CMP 1F, JMP 20), so the decoder and fetch share them.
- One natural sub-module: pc_next, combinational next-PC mux (soft_rst/jmp/pc_inc/hold with wrap). Everything else lives in fetch_unit.

Test Plan:
- Reset values: rst_n=0 for 3 edges, with imem_ack toggling -> pc=0, inst=0, inst_valid=0, imem_req=0, inst_count=0. One cycle after release, imem_req=1 and imem_addr=0.
- Sequential fetch with zero-wait memory returning 32'h01000201, 32'h02000007 with pc_inc=1 -> inst_valid pulses every 2nd cycle, addresses 0,1,2, inst_count=2 after two EXECs.
- Wait states: ack delayed 3 cycles -> imem_req and imem_addr stay high/stable for 3 cycles, IR unchanged until ack, inst_valid once.
- Jump: IR=32'h20150000, jmp=1, jmp_add=6'h15, pc_inc=0 -> next imem_addr=0x15. With soft_rst=1 in the same EXEC -> next imem_addr=0x00.
- Wrap and hold: pc=63 with pc_inc=1 -> next addr 0. pc=5 with pc_inc=0 and jmp=0 -> re-fetch addr 5, inst_count still increments.
- Reset mid-operation: rst_n=0 during FETCH with pending req at pc=9, ack arriving the next cycle -> IR stays 0, state IDLE, pc=0, the first post-reset fetch is addr 0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Constants and types shared by the instruction fetch stage and the decoder:
// address/instruction/counter widths, the fetch FSM state encoding, and the
// opcode values carried in the top byte of every instruction word.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int ADDR_W = 6;   // 64-word program space
  localparam int INST_W = 32;
  localparam int CNT_W  = 16;  // retired-instruction counter
  localparam int OP_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } fetch_state_t;

  // Opcode occupies inst[31:24]; 00 is what the decoder treats as a NOP,
  // which is why an all-zero IR is a safe reset value.
  localparam logic [OP_W-1:0] OP_NOP       = 8'h00;
  localparam logic [OP_W-1:0] OP_ALU_FIRST = 8'h01;
  localparam logic [OP_W-1:0] OP_ALU_LAST  = 8'h07;
  localparam logic [OP_W-1:0] OP_LOADI     = 8'h10;
  localparam logic [OP_W-1:0] OP_CMP       = 8'h1F;
  localparam logic [OP_W-1:0] OP_JMP       = 8'h20;

  function automatic logic [OP_W-1:0] opcode_of(input logic [INST_W-1:0] word);
    return word[INST_W-1 -: OP_W];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory request/acknowledge bus.
//   imem_req  : fetch request, held high until acknowledged
//   imem_addr : word address, stable while imem_req is high
//   imem_ack  : imem_data is valid this cycle (only meaningful with imem_req)
//   imem_data : fetched instruction word
// master = fetch unit, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// -----------------------------------------------------------------------------
// fetch_unit_pc_next
// Combinational next-PC selection for the EXEC cycle.
//   pc       : current program counter
//   soft_rst : decoder reset, forces 0 (highest priority)
//   jmp      : load jmp_add (wins over pc_inc)
//   jmp_add  : jump target
//   pc_inc   : advance by one, wrapping 63 -> 0
//   pc_nxt   : selected next PC; holds pc when nothing is asserted
// -----------------------------------------------------------------------------
module fetch_unit_pc_next
  import fetch_unit_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic              soft_rst,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_add,
  input  logic              pc_inc,
  output logic [ADDR_W-1:0] pc_nxt
);

  always_comb begin
    // NOTE: default assignment first so every path drives pc_nxt; no latch.
    pc_nxt = pc;
    if (soft_rst) begin
      pc_nxt = '0;
    end else if (jmp) begin
      pc_nxt = jmp_add;
    end else if (pc_inc) begin
      // Truncation to ADDR_W gives the modulo-64 wrap.
      pc_nxt = pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage in front of the decoder. Cycles IDLE -> FETCH ->
// EXEC -> FETCH ...; FETCH waits on the memory handshake, EXEC presents the
// instruction register for one cycle and then applies the decoder's PC
// controls.
//   clk, rst_n  : clock, synchronous active-low reset
//   imem        : instruction-memory bus (master side)
//   inst        : instruction register, feeds the decoder
//   inst_valid  : one-cycle pulse while inst is being executed
//   pc          : program counter (also drives imem_addr)
//   pc_inc, jmp, jmp_add, soft_rst : decoder controls, sampled at end of EXEC
//   inst_count  : number of EXEC cycles since reset (wraps)
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      imem,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  input  logic              pc_inc,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_add,
  input  logic              soft_rst,
  output logic [CNT_W-1:0]  inst_count
);

  fetch_state_t      state;
  logic              req_q;
  logic [ADDR_W-1:0] pc_nxt;

  fetch_unit_pc_next u_pc_next (
    .pc       (pc),
    .soft_rst (soft_rst),
    .jmp      (jmp),
    .jmp_add  (jmp_add),
    .pc_inc   (pc_inc),
    .pc_nxt   (pc_nxt)
  );

  // The address is the registered PC itself, so it cannot move while a
  // request is outstanding: pc only changes at the end of EXEC.
  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc;

  // req and inst_valid are registered alongside the state so they are
  // glitch-free and exactly track FETCH and EXEC respectively.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the IR is reset too, so the decoder sees a NOP rather than X
      // until the first real instruction arrives.
      state      <= IDLE;
      pc         <= '0;
      inst       <= {OP_NOP, {(INST_W-OP_W){1'b0}}};
      inst_count <= '0;
      req_q      <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every register samples the
      // pre-edge values, independent of statement order.
      case (state)
        IDLE: begin
          state <= FETCH;
          req_q <= 1'b1;
        end

        FETCH: begin
          if (imem.imem_ack) begin
            inst       <= imem.imem_data;
            state      <= EXEC;
            req_q      <= 1'b0;
            inst_valid <= 1'b1;
          end
        end

        EXEC: begin
          pc         <= pc_nxt;
          inst_count <= inst_count + CNT_W'(1);
          state      <= FETCH;
          req_q      <= 1'b1;
          inst_valid <= 1'b0;
        end

        default: begin
          state      <= IDLE;
          req_q      <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: reset checks, a table of directed
// instruction transactions (wait states, jumps, soft reset, wrap, hold),
// a reset in the middle of a fetch, then randomized memory timing and
// decoder controls checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic [ADDR_W-1:0] pc;
  logic              pc_inc;
  logic              jmp;
  logic [ADDR_W-1:0] jmp_add;
  logic              soft_rst;
  logic [CNT_W-1:0]  inst_count;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (bus),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc_inc     (pc_inc),
    .jmp        (jmp),
    .jmp_add    (jmp_add),
    .soft_rst   (soft_rst),
    .inst_count (inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One directed instruction transaction: fetch from addr after `waits`
  // un-acked cycles, execute with the given controls, expect `next` as the
  // following fetch address.
  typedef struct {
    int                waits;
    logic [INST_W-1:0] data;
    logic              inc;
    logic              jmp;
    logic [ADDR_W-1:0] jadd;
    logic              srst;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] next;
  } vec_t;

  vec_t              vecs[12];
  logic [INST_W-1:0] prev_inst;

  task automatic run_vec(input vec_t v, input int idx);
    check("vec_req_start", 64'(bus.imem_req), 64'd1);
    check("vec_addr_start", 64'(bus.imem_addr), 64'(v.addr));
    check("vec_valid_start", 64'(inst_valid), 64'd0);
    for (int w = 0; w < v.waits; w++) begin
      bus.imem_ack  = 1'b0;
      bus.imem_data = $urandom;
      @(negedge clk);
      check("wait_req_held", 64'(bus.imem_req), 64'd1);
      check("wait_addr_held", 64'(bus.imem_addr), 64'(v.addr));
      check("wait_no_valid", 64'(inst_valid), 64'd0);
      check("wait_ir_unchanged", 64'(inst), 64'(prev_inst));
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = v.data;
    @(negedge clk);
    bus.imem_ack  = 1'b0;
    bus.imem_data = $urandom;
    check("exec_valid", 64'(inst_valid), 64'd1);
    check("exec_inst", 64'(inst), 64'(v.data));
    check("exec_req_low", 64'(bus.imem_req), 64'd0);
    check("exec_pc", 64'(pc), 64'(v.addr));
    check("exec_count", 64'(inst_count), 64'(idx));
    pc_inc   = v.inc;
    jmp      = v.jmp;
    jmp_add  = v.jadd;
    soft_rst = v.srst;
    @(negedge clk);
    pc_inc   = 1'b0;
    jmp      = 1'b0;
    jmp_add  = '0;
    soft_rst = 1'b0;
    check("next_req", 64'(bus.imem_req), 64'd1);
    check("next_addr", 64'(bus.imem_addr), 64'(v.next));
    check("next_valid_low", 64'(inst_valid), 64'd0);
    check("next_inst_held", 64'(inst), 64'(v.data));
    check("next_count", 64'(inst_count), 64'(idx + 1));
    prev_inst = v.data;
  endtask

  // Reference model state (transaction level)
  int                exp_pc;
  int                exp_cnt;
  logic [INST_W-1:0] last_inst;
  logic [INST_W-1:0] pend_data;
  logic [OP_W-1:0]   pend_op;
  bit                expect_exec;
  bit                expect_fetch;
  logic [OP_W-1:0]   ops[6];

  initial begin
    rst_n         = 1'b0;
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    pc_inc        = 1'b0;
    jmp           = 1'b0;
    jmp_add       = '0;
    soft_rst      = 1'b0;
    prev_inst     = '0;

    //          waits data          inc jmp jadd   srst addr   next
    vecs[0]  = '{0, 32'h01000201, 1'b1, 1'b0, 6'h00, 1'b0, 6'h00, 6'h01};
    vecs[1]  = '{0, 32'h02000007, 1'b1, 1'b0, 6'h00, 1'b0, 6'h01, 6'h02};
    vecs[2]  = '{3, 32'h10000005, 1'b1, 1'b0, 6'h00, 1'b0, 6'h02, 6'h03};
    vecs[3]  = '{0, 32'h20150000, 1'b0, 1'b1, 6'h15, 1'b0, 6'h03, 6'h15};
    vecs[4]  = '{1, 32'h202A0000, 1'b1, 1'b1, 6'h2A, 1'b0, 6'h15, 6'h2A};
    vecs[5]  = '{0, 32'h20050000, 1'b0, 1'b1, 6'h05, 1'b1, 6'h2A, 6'h00};
    vecs[6]  = '{0, 32'h203F0000, 1'b0, 1'b1, 6'h3F, 1'b0, 6'h00, 6'h3F};
    vecs[7]  = '{2, 32'h1F000000, 1'b1, 1'b0, 6'h00, 1'b0, 6'h3F, 6'h00};
    vecs[8]  = '{0, 32'h20050000, 1'b0, 1'b1, 6'h05, 1'b0, 6'h00, 6'h05};
    vecs[9]  = '{0, 32'h00000000, 1'b0, 1'b0, 6'h00, 1'b0, 6'h05, 6'h05};
    vecs[10] = '{0, 32'h03000102, 1'b1, 1'b0, 6'h00, 1'b0, 6'h05, 6'h06};
    vecs[11] = '{0, 32'h20090000, 1'b0, 1'b1, 6'h09, 1'b0, 6'h06, 6'h09};

    // Reset held for 3 edges while ack toggles.
    repeat (3) begin
      @(negedge clk);
      bus.imem_ack  = ~bus.imem_ack;
      bus.imem_data = $urandom;
      @(posedge clk);
    end
    @(negedge clk);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_inst", 64'(inst), 64'd0);
    check("rst_valid", 64'(inst_valid), 64'd0);
    check("rst_req", 64'(bus.imem_req), 64'd0);
    check("rst_count", 64'(inst_count), 64'd0);
    rst_n        = 1'b1;
    bus.imem_ack = 1'b0;
    @(negedge clk);
    check("post_rst_req", 64'(bus.imem_req), 64'd1);
    check("post_rst_addr", 64'(bus.imem_addr), 64'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset while fetching at pc=9, with the ack arriving one cycle late.
    check("mid_pre_addr", 64'(bus.imem_addr), 64'd9);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n         = 1'b1;
    bus.imem_ack  = 1'b1;
    bus.imem_data = 32'hDEADBEEF;
    check("mid_req_dropped", 64'(bus.imem_req), 64'd0);
    check("mid_pc", 64'(pc), 64'd0);
    check("mid_inst", 64'(inst), 64'd0);
    check("mid_count", 64'(inst_count), 64'd0);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("late_ack_ignored", 64'(inst), 64'd0);
    check("late_ack_no_valid", 64'(inst_valid), 64'd0);
    check("mid_refetch_req", 64'(bus.imem_req), 64'd1);
    check("mid_refetch_addr", 64'(bus.imem_addr), 64'd0);

    // Randomized phase against the transaction-level model.
    ops          = '{OP_NOP, OP_ALU_FIRST, OP_ALU_LAST, OP_LOADI, OP_CMP, OP_JMP};
    exp_pc       = 0;
    exp_cnt      = 0;
    last_inst    = '0;
    pend_data    = '0;
    pend_op      = '0;
    expect_exec  = 1'b0;
    expect_fetch = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd_pc", 64'(pc), 64'(exp_pc));
      if (expect_exec) begin
        check("rnd_valid", 64'(inst_valid), 64'd1);
        check("rnd_inst", 64'(inst), 64'(pend_data));
        check("rnd_opcode", 64'(opcode_of(inst)), 64'(pend_op));
        check("rnd_count", 64'(inst_count), 64'(exp_cnt));
      end else begin
        check("rnd_no_valid", 64'(inst_valid), 64'd0);
        check("rnd_inst_held", 64'(inst), 64'(last_inst));
      end
      if (expect_fetch) begin
        check("rnd_req", 64'(bus.imem_req), 64'd1);
        check("rnd_addr", 64'(bus.imem_addr), 64'(exp_pc));
      end else begin
        check("rnd_req_low", 64'(bus.imem_req), 64'd0);
      end

      bus.imem_ack = ($urandom_range(0, 2) == 0);
      pend_op      = ops[$urandom_range(0, 5)];
      bus.imem_data = {pend_op, 24'($urandom)};
      pc_inc   = ($urandom_range(0, 3) != 0);
      jmp      = ($urandom_range(0, 3) == 0);
      jmp_add  = ADDR_W'($urandom);
      soft_rst = ($urandom_range(0, 15) == 0);

      if (expect_exec) begin
        if (soft_rst)    exp_pc = 0;
        else if (jmp)    exp_pc = int'(jmp_add);
        else if (pc_inc) exp_pc = (exp_pc + 1) % 64;
        exp_cnt      = (exp_cnt + 1) % 65536;
        last_inst    = pend_data;
        expect_exec  = 1'b0;
        expect_fetch = 1'b1;
      end else if (expect_fetch && bus.imem_ack) begin
        pend_data    = bus.imem_data;
        expect_exec  = 1'b1;
        expect_fetch = 1'b0;
      end else begin
        pend_op = opcode_of(pend_data);
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
